// File: rtl/mc_core_seq_if.sv
// mc_core_seq_if: shared instruction/data memory bus with req/ready handshake
interface mc_core_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mc_core_seq.sv
// mc_core_seq: parametrised multicycle CPU core; define MC_CORE_MUL_EN to make opcode B an unsigned MUL
module mc_core_seq #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 16,
  parameter int          NREG     = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  mc_core_seq_if.master     bus,
  output logic [ADDR_W-1:0] pc_o,
  output logic [3:0]        flags_o,
  output logic              retire,
  output logic              illegal,
  output logic              halted
);
`ifdef MC_CORE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam int M = DATA_W - 1;

  logic [2:0]        state;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] a, b, acc, mdr, mar;
  logic [3:0]        flags;
  logic [DATA_W-1:0] regs [NREG];

  logic [3:0]        op, rd, rs, rt;
  logic [DATA_W-1:0] se4, se8, se12;
  logic [DATA_W-1:0] rf_rs, rf_rt, rf_rd, b_sel;
  logic              legal, is_mul, flag_upd, c_res, v_res;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff, prod, res;

  assign op = ir[15:12];
  assign rd = ir[11:8];
  assign rs = ir[7:4];
  assign rt = ir[3:0];
  assign se4  = {{(DATA_W-4){ir[3]}}, ir[3:0]};
  assign se8  = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign se12 = {{(DATA_W-12){ir[11]}}, ir[11:0]};

  // register reads: out-of-range indices read as zero
  always_comb begin
    rf_rs = int'(rs) < NREG ? regs[rs] : '0;
    rf_rt = int'(rt) < NREG ? regs[rt] : '0;
    rf_rd = int'(rd) < NREG ? regs[rd] : '0;
  end

  // decode: legality and the B operand source
  always_comb begin
    is_mul   = MUL_EN && op == 4'hB;
    legal    = op <= 4'hA || op == 4'hF || is_mul;
    flag_upd = op <= 4'h5 || is_mul;
    b_sel    = (op <= 4'h4 || is_mul) ? rf_rt :
               (op == 4'h5 || op == 4'h7 || op == 4'h8) ? se4 :
               (op == 4'h6 || op == 4'h9) ? se8 : se12;
  end

  // ALU: loads/stores reuse the adder for the effective address, LI passes B through
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = a - b;
    prod  = a * b;
    res   = op == 4'h1 ? diff :
            op == 4'h2 ? (a & b) :
            op == 4'h3 ? (a | b) :
            op == 4'h4 ? (a ^ b) :
            op == 4'h6 ? b :
            is_mul     ? prod : sum[M:0];
    c_res = (op == 4'h0 || op == 4'h5) ? sum[DATA_W] : op == 4'h1 ? (a >= b) : 1'b0;
    v_res = (op == 4'h0 || op == 4'h5) ? (a[M] == b[M] && sum[M] != a[M]) :
            op == 4'h1 ? (a[M] != b[M] && diff[M] != a[M]) : 1'b0;
  end

  assign bus.mem_req   = !rst && (state == S_FETCH || state == S_MEM);
  assign bus.mem_we    = state == S_MEM && op == 4'h8;
  assign bus.mem_addr  = state == S_MEM ? mar[ADDR_W-1:0] : pc;
  assign bus.mem_wdata = mdr;
  assign pc_o          = pc;
  assign flags_o       = flags;
  assign halted        = state == S_HALT;

  // register file: written only in WB, indices beyond NREG are dropped
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == S_WB && int'(rd) < NREG) begin
      regs[rd] <= acc;
    end

  // control FSM and datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= S_FETCH;
      pc      <= ADDR_W'(RESET_PC);
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      acc     <= '0;
      mdr     <= '0;
      mar     <= '0;
      flags   <= '0;
      retire  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      retire  <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_FETCH:
          if (bus.mem_ready) begin
            ir    <= bus.mem_rdata[15:0];
            pc    <= pc + ADDR_W'(1);
            state <= S_DECODE;
          end
        S_DECODE: begin
          a   <= rf_rs;
          b   <= b_sel;
          mdr <= rf_rd;
          if (op == 4'hF) state <= S_HALT;
          else if (!legal) begin
            illegal <= 1'b1;
            retire  <= 1'b1;
            state   <= S_FETCH;
          end else state <= S_EXEC;
        end
        S_EXEC: begin
          acc <= res;
          mar <= res;
          if (flag_upd) flags <= {res[M], res == '0, c_res, v_res};
          if (op == 4'h7 || op == 4'h8) state <= S_MEM;
          else if (op == 4'h9 || op == 4'hA) begin
            if (op == 4'hA || mdr == '0) pc <= pc + b[ADDR_W-1:0];
            retire <= 1'b1;
            state  <= S_FETCH;
          end else state <= S_WB;
        end
        S_MEM:
          if (bus.mem_ready) begin
            if (op == 4'h7) begin
              acc   <= bus.mem_rdata;
              state <= S_WB;
            end else begin
              retire <= 1'b1;
              state  <= S_FETCH;
            end
          end
        S_WB: begin
          retire <= 1'b1;
          state  <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
endmodule

// File: tb/tb_mc_core_seq.sv
// tb_mc_core_seq: program-driven bench with wait-state memory model and store scoreboard
module tb_mc_core_seq;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] pc_o;
  logic [3:0] flags_o;
  logic retire, illegal, halted;

  mc_core_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  mc_core_seq #(.DATA_W(DW), .ADDR_W(AW), .NREG(16), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pc_o(pc_o), .flags_o(flags_o),
    .retire(retire), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int fails = 0;
  int wait_n = 0;
  int cnt = 0;
  logic [15:0] mem [256];
  logic [31:0] exp_st[$];
  logic [31:0] obs_st[$];
  int ret_cyc[$];
  logic [3:0] ret_fl[$];
  logic [15:0] ret_pc[$];
  int cyc = 0, ill_cnt = 0, we_cyc = 0, we4_cyc = 0, rd4_cyc = 0;

  // memory responder: grants after wait_n wait cycles, logs completed stores
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (rst) begin
        obs_st.delete();
        cnt = 0;
      end else if (bus.mem_req) begin
        if (cnt >= wait_n) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr[7:0]];
          if (bus.mem_we) begin
            mem[bus.mem_addr[7:0]] = bus.mem_wdata;
            obs_st.push_back({bus.mem_addr, bus.mem_wdata});
          end
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // observer: retire timing/flags/pc and bus activity
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      ret_cyc.delete(); ret_fl.delete(); ret_pc.delete();
      ill_cnt = 0; we_cyc = 0; we4_cyc = 0; rd4_cyc = 0;
    end else begin
      if (retire) begin
        ret_cyc.push_back(cyc); ret_fl.push_back(flags_o); ret_pc.push_back(pc_o);
      end
      if (illegal) ill_cnt++;
      if (bus.mem_req && bus.mem_we) begin
        we_cyc++;
        if (bus.mem_addr == 16'h0004 && bus.mem_wdata == 16'h0005) we4_cyc++;
      end
      if (bus.mem_req && !bus.mem_we && bus.mem_addr == 16'h0004) rd4_cyc++;
    end
  end

  task automatic fill();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    exp_st.delete();
  endtask

  task automatic start(input int w);
    rst = 1'b1;
    wait_n = w;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic run_halt(input int limit);
    for (int i = 0; i < limit && !halted; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_n = 0;
    repeat (3) @(posedge clk);
    #2;
    asserts++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", bus.mem_req); end
    asserts++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b exp 0", bus.mem_we); end
    asserts++; if (pc_o !== 16'h0000) begin fails++; $display("FAIL reset_pc got %h exp 0000", pc_o); end
    asserts++; if (flags_o !== 4'h0) begin fails++; $display("FAIL reset_flags got %b exp 0000", flags_o); end
    asserts++; if (retire !== 1'b0) begin fails++; $display("FAIL reset_retire got %b exp 0", retire); end
    asserts++; if (illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    asserts++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b exp 0", halted); end
  endtask

  task automatic test_alu;
    logic [31:0] e, o;
    fill();
    mem[0] = 16'h6105; mem[1] = 16'h62FD; mem[2] = 16'h0312; mem[3] = 16'h6540; mem[4] = 16'h8350;
    exp_st.push_back({16'h0040, 16'h0002});
    start(0);
    run_halt(200);
    asserts++; if (halted !== 1'b1) begin fails++; $display("FAIL alu_halt got %b exp 1", halted); end
    asserts++; if (ret_cyc.size() !== 5) begin fails++; $display("FAIL alu_retires got %0d exp 5", ret_cyc.size()); end
    asserts++; if (ret_fl[2] !== 4'b0010) begin fails++; $display("FAIL alu_add_flags got %b exp 0010", ret_fl[2]); end
    asserts++; if (ret_cyc[2] - ret_cyc[1] !== 4) begin fails++; $display("FAIL alu_add_latency got %0d exp 4", ret_cyc[2] - ret_cyc[1]); end
    asserts++; if (pc_o !== 16'h0006) begin fails++; $display("FAIL alu_final_pc got %h exp 0006", pc_o); end
    asserts++; if (obs_st.size() !== exp_st.size()) begin fails++; $display("FAIL alu_st_count got %0d exp %0d", obs_st.size(), exp_st.size()); end
    while (exp_st.size() > 0) begin
      e = exp_st.pop_front();
      o = obs_st.size() > 0 ? obs_st.pop_front() : 32'hxxxxxxxx;
      asserts++; if (o !== e) begin fails++; $display("FAIL alu_store got %h exp %h", o, e); end
    end
  endtask

  task automatic test_branch;
    logic [31:0] e, o;
    fill();
    mem[0] = 16'h6105; mem[1] = 16'h1311; mem[2] = 16'h9302; mem[3] = 16'h6177;
    mem[4] = 16'h6178; mem[5] = 16'h6540; mem[6] = 16'h8150;
    exp_st.push_back({16'h0040, 16'h0005});
    start(0);
    run_halt(200);
    asserts++; if (halted !== 1'b1) begin fails++; $display("FAIL br_halt got %b exp 1", halted); end
    asserts++; if (ret_fl[1] !== 4'b0110) begin fails++; $display("FAIL br_sub_flags got %b exp 0110", ret_fl[1]); end
    asserts++; if (ret_cyc[2] - ret_cyc[1] !== 3) begin fails++; $display("FAIL br_latency got %0d exp 3", ret_cyc[2] - ret_cyc[1]); end
    asserts++; if (ret_pc[2] !== 16'h0005) begin fails++; $display("FAIL br_target got %h exp 0005", ret_pc[2]); end
    asserts++; if (pc_o !== 16'h0008) begin fails++; $display("FAIL br_final_pc got %h exp 0008", pc_o); end
    asserts++; if (obs_st.size() !== exp_st.size()) begin fails++; $display("FAIL br_st_count got %0d exp %0d", obs_st.size(), exp_st.size()); end
    while (exp_st.size() > 0) begin
      e = exp_st.pop_front();
      o = obs_st.size() > 0 ? obs_st.pop_front() : 32'hxxxxxxxx;
      asserts++; if (o !== e) begin fails++; $display("FAIL br_store got %h exp %h", o, e); end
    end
  endtask

  task automatic test_mem_wait;
    logic [31:0] e, o;
    fill();
    mem[0] = 16'h6105; mem[1] = 16'h8104; mem[2] = 16'h7404; mem[3] = 16'hA001;
    mem[4] = 16'h0000; mem[5] = 16'h6540; mem[6] = 16'h8450;
    exp_st.push_back({16'h0004, 16'h0005});
    exp_st.push_back({16'h0040, 16'h0005});
    start(3);
    run_halt(400);
    asserts++; if (halted !== 1'b1) begin fails++; $display("FAIL mw_halt got %b exp 1", halted); end
    asserts++; if (we4_cyc !== 4) begin fails++; $display("FAIL mw_st_stable got %0d exp 4", we4_cyc); end
    asserts++; if (we_cyc !== 8) begin fails++; $display("FAIL mw_we_cycles got %0d exp 8", we_cyc); end
    asserts++; if (rd4_cyc !== 4) begin fails++; $display("FAIL mw_ld_stable got %0d exp 4", rd4_cyc); end
    asserts++; if (ret_cyc[2] - ret_cyc[1] !== 11) begin fails++; $display("FAIL mw_ld_latency got %0d exp 11", ret_cyc[2] - ret_cyc[1]); end
    asserts++; if (obs_st.size() !== exp_st.size()) begin fails++; $display("FAIL mw_st_count got %0d exp %0d", obs_st.size(), exp_st.size()); end
    while (exp_st.size() > 0) begin
      e = exp_st.pop_front();
      o = obs_st.size() > 0 ? obs_st.pop_front() : 32'hxxxxxxxx;
      asserts++; if (o !== e) begin fails++; $display("FAIL mw_store got %h exp %h", o, e); end
    end
  endtask

  task automatic test_illegal;
    logic [31:0] e, o;
    fill();
    mem[0] = 16'h6105; mem[1] = 16'h1311; mem[2] = 16'hC123; mem[3] = 16'hB123;
    mem[4] = 16'h6540; mem[5] = 16'h8150; mem[6] = 16'h8350;
    exp_st.push_back({16'h0040, 16'h0005});
    exp_st.push_back({16'h0040, 16'h0000});
    start(0);
    run_halt(200);
    asserts++; if (ill_cnt !== 2) begin fails++; $display("FAIL ill_count got %0d exp 2", ill_cnt); end
    asserts++; if (ret_cyc.size() !== 7) begin fails++; $display("FAIL ill_retires got %0d exp 7", ret_cyc.size()); end
    asserts++; if (ret_fl[3] !== 4'b0110) begin fails++; $display("FAIL ill_flags got %b exp 0110", ret_fl[3]); end
    asserts++; if (ret_pc[2] !== 16'h0003) begin fails++; $display("FAIL ill_pc_c got %h exp 0003", ret_pc[2]); end
    asserts++; if (ret_pc[3] !== 16'h0004) begin fails++; $display("FAIL ill_pc_b got %h exp 0004", ret_pc[3]); end
    asserts++; if (ret_cyc[3] - ret_cyc[2] !== 2) begin fails++; $display("FAIL ill_latency got %0d exp 2", ret_cyc[3] - ret_cyc[2]); end
    asserts++; if (obs_st.size() !== exp_st.size()) begin fails++; $display("FAIL ill_st_count got %0d exp %0d", obs_st.size(), exp_st.size()); end
    while (exp_st.size() > 0) begin
      e = exp_st.pop_front();
      o = obs_st.size() > 0 ? obs_st.pop_front() : 32'hxxxxxxxx;
      asserts++; if (o !== e) begin fails++; $display("FAIL ill_store got %h exp %h", o, e); end
    end
  endtask

  task automatic test_jmp_halt;
    int bad;
    int req_seen;
    fill();
    mem[0] = 16'hA00F; mem[16] = 16'hAFFF;
    start(0);
    repeat (40) @(posedge clk);
    #2;
    bad = 0;
    foreach (ret_pc[i]) if (ret_pc[i] !== 16'h0010) bad++;
    asserts++; if (ret_cyc.size() < 5) begin fails++; $display("FAIL jmp_retires got %0d exp >=5", ret_cyc.size()); end
    asserts++; if (bad !== 0) begin fails++; $display("FAIL jmp_selfloop got %0d off-target exp 0", bad); end
    asserts++; if (halted !== 1'b0) begin fails++; $display("FAIL jmp_halted got %b exp 0", halted); end
    fill();
    start(0);
    run_halt(20);
    req_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #2;
      if (bus.mem_req) req_seen++;
    end
    asserts++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_flag got %b exp 1", halted); end
    asserts++; if (req_seen !== 0) begin fails++; $display("FAIL halt_req got %0d cycles exp 0", req_seen); end
    asserts++; if (ret_cyc.size() !== 0) begin fails++; $display("FAIL halt_retire got %0d exp 0", ret_cyc.size()); end
    asserts++; if (pc_o !== 16'h0001) begin fails++; $display("FAIL halt_pc got %h exp 0001", pc_o); end
  endtask

  task automatic test_reset_mid;
    bit found;
    fill();
    mem[0] = 16'h7404;
    start(20);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #2;
      if (bus.mem_req && !bus.mem_we && bus.mem_addr == 16'h0004) found = 1'b1;
    end
    asserts++; if (found !== 1'b1) begin fails++; $display("FAIL rm_ld_seen got %b exp 1", found); end
    #1 rst = 1'b1;
    #1;
    asserts++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rm_req_drop got %b exp 0", bus.mem_req); end
    asserts++; if (pc_o !== 16'h0000) begin fails++; $display("FAIL rm_pc got %h exp 0000", pc_o); end
    repeat (2) @(posedge clk);
    #2;
    wait_n = 0;
    rst = 1'b0;
    #1;
    asserts++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL rm_fetch_req got %b exp 1", bus.mem_req); end
    asserts++; if (bus.mem_addr !== 16'h0000) begin fails++; $display("FAIL rm_fetch_addr got %h exp 0000", bus.mem_addr); end
    run_halt(100);
    asserts++; if (halted !== 1'b1) begin fails++; $display("FAIL rm_halt got %b exp 1", halted); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_mem_wait();
    test_illegal();
    test_jmp_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/mc_core_seq.md
Name: mc_core_seq

Overview:
- Parametrised multicycle CPU core. It is the successor to the fixed 16-bit datapath.
- Integrates the PC, IR, MAR/MDR, A/B/ACC, flags, register file, ALU and sign extenders with its own control FSM.
- Generalised in data width, address width and register count.
- Talks to one shared instruction/data memory over a req/ready handshake, so it tolerates wait states.
- Sits between the top-level SoC wrapper and the memory block.

Parameters:
DATA_W, 16, datapath/register width; legal range 16..32.
ADDR_W, 16, word address width; legal range 8..DATA_W.
NREG, 16, number of architectural registers; legal range 2..16.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
mem_req  output  1  memory request, held until accepted
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  word address
mem_wdata  output  DATA_W  store data
mem_rdata  input  DATA_W  read data; valid in the cycle mem_ready is high
mem_ready  input  1  request accepted/completed this cycle
pc_o  output  ADDR_W  current PC
flags_o  output  4  {N,Z,C,V}
retire  output  1  one-cycle pulse per completed instruction
illegal  output  1  one-cycle pulse on an undefined opcode
halted  output  1  high while in HALT

Behaviour:
- Reset (async) values: PC = RESET_PC; IR/A/B/ACC/MDR/MAR = 0; all registers = 0; flags = 0; mem_req = 0; mem_we = 0; retire = 0; illegal = 0; halted = 0; state = FETCH.
- Instruction format: fixed 16 bits, fetched from mem_rdata[15:0]; op = [15:12], rd = [11:8], rs = [7:4], rt/imm4 = [3:0], imm8 = [7:0], imm12 = [11:0].
- Immediates are sign-extended to DATA_W.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: rd = rs op rt.
  - 5 ADDI: rd = rs + se(imm4).
  - 6 LI: rd = se(imm8).
  - 7 LD: rd = mem[rs + se(imm4)].
  - 8 ST: mem[rs + se(imm4)] = rd.
  - 9 BEQZ: if rd == 0, PC = PC + se(imm8).
  - A JMP: PC = PC + se(imm12).
  - F HALT.
  - Others are illegal.
- Branch/jump offsets are relative to the already-incremented PC (address of instruction + 1). Address arithmetic wraps modulo 2^ADDR_W.
- Register index >= NREG: reads return 0, writes are dropped. r0 is a normal register.
- Flags are updated only by ops 0-5.
  - Z = result == 0; N = result MSB.
  - C = carry out (ADD/ADDI) or borrow-free, i.e. rs >= rt unsigned (SUB).
  - V = signed overflow.
  - AND/OR/XOR clear C and V.
- FSM states:
  - FETCH: mem_req = 1, mem_we = 0, mem_addr = PC. On mem_ready: IR <= rdata[15:0], PC <= PC + 1, go to DECODE.
  - DECODE: A <= R[rs]; B <= R[rt] or sign-extended immediate; MDR <= R[rd]. HALT goes to HALT. Illegal opcode pulses illegal, pulses retire, and returns to FETCH (treated as NOP).
  - EXEC: ALU -> ACC (also the effective address -> MAR). LD/ST go to MEM. BEQZ/JMP update PC, pulse retire, go to FETCH. Others go to WB.
  - MEM: mem_req = 1, mem_addr = MAR[ADDR_W-1:0]; mem_we = 1 with mem_wdata = MDR for ST. On mem_ready: LD latches rdata into ACC and goes to WB; ST pulses retire and goes to FETCH.
  - WB: R[rd] <= ACC, pulse retire, go to FETCH.
  - HALT: terminal; halted = 1, mem_req = 0. Only reset exits.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req is high and mem_ready is low.
  - mem_ready asserted in the same cycle as mem_req completes the access (zero wait).
  - mem_ready while mem_req = 0 is ignored.
- Latency at zero wait states:
  - ALU op: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - Branch/jump: 3 cycles.
  - Each wait state adds 1 cycle.
- Reset mid-access: mem_req drops immediately (async); any partial transaction is abandoned.

Optional Feature:
- Macro MC_CORE_MUL_EN.
- When defined: opcode B = MUL, rd = low DATA_W bits of rs * rt (unsigned); Z/N updated, C/V cleared; latency equals ADD.
- When undefined: opcode B is illegal (illegal pulse, NOP).

Test Plan:
1. Reset then LI r1,5; LI r2,-3; ADD r3,r1,r2 with zero-wait memory -> r3 = 2, flags C = 1, Z = 0, N = 0, V = 0; retire pulses 4 cycles apart for ADD.
2. SUB r3,r1,r1 -> r3 = 0, Z = 1, C = 1. Then BEQZ r3,+2 -> PC skips two instructions; retire 3 cycles after the fetch starts.
3. ST r1,[r0+4] then LD r4,[r0+4], with mem_ready delayed 3 cycles per access -> mem_addr = 4 and mem_wdata = 5 stable across the waits; r4 = 5.
4. Opcode C, and opcode B without MC_CORE_MUL_EN -> illegal pulses once per instruction; registers/flags unchanged; PC advances by 1.
5. JMP -1 at address 0x0010 -> PC = 0x0010 (self-loop). HALT -> halted = 1, mem_req held 0 indefinitely.
6. Assert rst while mem_req is high mid-LD wait -> mem_req = 0 in the same cycle; after release, first fetch is from RESET_PC.
